// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control_unit opcodes, sequencer state
// encodings, pc_src / wb_sel codes and the latched decode-flag bundle.
package cpu_pkg;

    // control_unit opcode constants
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_MUL  = 6'h02;
    localparam logic [5:0] OP_DIV  = 6'h03;
    localparam logic [5:0] OP_MOD  = 6'h04;
    localparam logic [5:0] OP_LD   = 6'h10;
    localparam logic [5:0] OP_ST   = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h18;
    localparam logic [5:0] OP_BGT  = 6'h19;
    localparam logic [5:0] OP_B    = 6'h1a;
    localparam logic [5:0] OP_CALL = 6'h1b;
    localparam logic [5:0] OP_RET  = 6'h1c;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_RET    = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    // Decode flags captured once per instruction in DECODE
    typedef struct packed {
        logic ld;
        logic st;
        logic wb;
        logic call;
        logic ret;
        logic ubranch;
        logic multi;
        logic taken;
    } ctrl_flags_t;

    function automatic logic [1:0] retire_pc_src(input ctrl_flags_t f);
        if (f.ret)
            return PC_RET;
        else if (f.ubranch || f.call || f.taken)
            return PC_BRANCH;
        else
            return PC_SEQ;
    endfunction

    function automatic logic [1:0] wb_select(input ctrl_flags_t f);
        if (f.call)
            return WB_LINK;
        else if (f.ld)
            return WB_MEM;
        else
            return WB_ALU;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait watchdog. Down-counter reloaded on clear; expired flags
// the MAX_WAIT-th consecutive enabled cycle so the caller can still let
// an acknowledge in that same cycle win.
module wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [TW-1:0] LOAD = TW'(MAX_WAIT - 1);

    logic [TW-1:0] remain_q;

    // Reload on reset/clear, otherwise count down while waiting
    always_ff @(posedge clk) begin
        if (rst || clear)
            remain_q <= LOAD;
        else if (enable && (remain_q != '0))
            remain_q <= remain_q - TW'(1);
    end

    assign expired = enable && (remain_q == '0);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch / decode / execute / memory /
// write-back with a memory-wait watchdog and retired-instruction counter.
//
//   state  | meaning
//   FETCH  | instruction read pending, waits for mem_ack
//   DECODE | one cycle, decode flags captured
//   EXEC   | ALU op; multi-cycle ops hold here until alu_done
//   MEM    | load/store pending, waits for mem_ack
//   WB     | one-cycle register write
//   FAULT  | memory never answered; sticky until rst
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             isLd,
    input  logic             isSt,
    input  logic             isWb,
    input  logic             isCall,
    input  logic             isRet,
    input  logic             isUBranch,
    input  logic             isMulti,
    input  logic             branch_taken,
    input  logic             mem_ack,
    input  logic             alu_done,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             alu_start,
    output logic             regwrite,
    output logic             fault,
    output logic [1:0]       pc_src,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t            state_q, state_d;
    ctrl_flags_t       flags_q;
    logic              exec_first_q;
    logic [CNT_W-1:0]  retired_q;
    logic              retire;
    logic              waiting;
    logic              tmr_clear;
    logic              tmr_expired;
    logic              exec_done;

    assign waiting   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign exec_done = !flags_q.multi || alu_done;
    assign tmr_clear = (waiting && mem_ack) || (state_d != state_q);

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (waiting),
        .expired (tmr_expired)
    );

    // State register, flag capture and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            flags_q      <= '0;
            exec_first_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            exec_first_q <= (state_q == ST_DECODE);
            if (state_q == ST_DECODE) begin
                flags_q.ld      <= isLd;
                flags_q.st      <= isSt;
                flags_q.wb      <= isWb;
                flags_q.call    <= isCall;
                flags_q.ret     <= isRet;
                flags_q.ubranch <= isUBranch;
                flags_q.multi   <= isMulti;
                flags_q.taken   <= branch_taken;
            end
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Next-state and strobe decode; reset masks every write strobe so an
    // in-flight write is dropped rather than completed
    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        ir_write  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        alu_start = 1'b0;
        regwrite  = 1'b0;
        wb_sel    = WB_ALU;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                alu_start = flags_q.multi && exec_first_q;
                if (exec_done) begin
                    if (flags_q.ld || flags_q.st)
                        state_d = ST_MEM;
                    else if (flags_q.wb || flags_q.call)
                        state_d = ST_WB;
                    else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = flags_q.st;
                if (mem_ack) begin
                    if (flags_q.ld)
                        state_d = ST_WB;
                    else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                regwrite = 1'b1;
                wb_sel   = wb_select(flags_q);
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FETCH;
        endcase
        if (rst) begin
            ir_write  = 1'b0;
            mem_we    = 1'b0;
            alu_start = 1'b0;
            regwrite  = 1'b0;
            retire    = 1'b0;
        end
    end

    assign pc_write = retire;
    assign pc_src   = retire ? retire_pc_src(flags_q) : PC_SEQ;
    assign fault    = (state_q == ST_FAULT);
    assign state    = state_q;
    assign retired  = retired_q;

endmodule
